comparator_pipe: RTL

//  Parametrised, 2-stage pipelined magnitude comparator; generalises the 4-bit slice comparator to WIDTH bits.

---
 rtl/cmp_pkg.sv | 22 ++
 rtl/comparator_slice.sv | 23 ++
 rtl/comparator_pipe.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the comparator pipe: operation mode, packed result
// flags and the IEEE-754 single field widths used by the FP path.
package cmp_pkg;

   typedef enum logic [1:0] {
      CMP_UNS = 2'b00,
      CMP_SGN = 2'b01,
      CMP_FP  = 2'b10,
      CMP_RSV = 2'b11
   } cmp_mode_e;

   typedef struct packed {
      logic equal;
      logic larger;
      logic smaller;
      logic unord;
   } cmp_res_t;

   localparam int FP_EXP_W = 8;
   localparam int FP_MAN_W = 23;

endpackage

// File: rtl/comparator_slice.sv
// Combinational magnitude compare of one CHUNK-bit slice.
//   i_a, i_b : slice operands
//   o_eq     : i_a == i_b
//   o_gt     : i_a >  i_b (unsigned)
module comparator_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   output logic             o_eq,
   output logic             o_gt
);

   always_comb begin
      o_eq = &(i_a ~^ i_b);
      o_gt = 1'b0;
      // Later (higher) differing bits overwrite earlier ones: msb-first priority.
      for (int i = 0; i < CHUNK; i++) begin
         if (i_a[i] != i_b[i]) o_gt = i_a[i];
      end
   end

endmodule

// File: rtl/comparator_pipe.sv
// Two-stage pipelined WIDTH-bit magnitude comparator (unsigned, signed and,
// when CMP_FP_MODE_EN is defined, IEEE-754 single).
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     operand handshake
//   i_a, i_b, i_mode      operands and mode (00 UNS, 01 SGN, 10 FP, 11 = UNS)
//   i_tag / o_tag         side-band tag, returned with the result
//   o_valid / i_ready     result handshake
//   o_equal, o_larger, o_smaller, o_unord   one-hot result while o_valid
// Macro CMP_FP_MODE_EN: builds the FP path; otherwise mode 10 acts as UNS
// and o_unord is always 0.
module comparator_pipe
   import cmp_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CHUNK = 4,
   parameter int TAG_W = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [1:0]       i_mode,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_valid,
   input  logic             i_ready,
   output logic             o_equal,
   output logic             o_larger,
   output logic             o_smaller,
   output logic             o_unord,
   output logic [TAG_W-1:0] o_tag
);

   localparam int NCH = WIDTH / CHUNK;

`ifdef CMP_FP_MODE_EN
   if (WIDTH != 32) begin : g_fp_width_chk
      $error("comparator_pipe: FP mode requires WIDTH == 32");
   end
`endif

   cmp_mode_e        mode_eff;
   logic [WIDTH-1:0] a_x, b_x;
   logic [NCH-1:0]   eq_d, gt_d;
   logic [NCH-1:0]   eq_q, gt_q;
   logic [TAG_W-1:0] tag1_q;
   logic             s1_valid_q;

   logic             s2_valid_q;
   cmp_res_t         res_d, res_q;
   logic [TAG_W-1:0] tag2_q;

   logic             s2_load, s1_adv, accept;
   logic             mag_eq, mag_gt;

   assign s2_load = ~s2_valid_q | i_ready;
   assign s1_adv  = s2_load;
   assign o_ready = ~s1_valid_q | s1_adv;
   assign accept  = i_valid & o_ready;

   always_comb begin
      mode_eff = CMP_UNS;
      if (i_mode == CMP_SGN) mode_eff = CMP_SGN;
`ifdef CMP_FP_MODE_EN
      if (i_mode == CMP_FP) mode_eff = CMP_FP;
`endif
   end

   // Signed compare becomes unsigned once the sign bits are flipped; FP
   // compares magnitudes only, sign handling happens in stage 2.
   always_comb begin
      a_x = i_a;
      b_x = i_b;
      if (mode_eff == CMP_SGN) begin
         a_x[WIDTH-1] = ~i_a[WIDTH-1];
         b_x[WIDTH-1] = ~i_b[WIDTH-1];
      end
`ifdef CMP_FP_MODE_EN
      if (mode_eff == CMP_FP) begin
         a_x[WIDTH-1] = 1'b0;
         b_x[WIDTH-1] = 1'b0;
      end
`endif
   end

   for (genvar g = 0; g < NCH; g++) begin : g_slice
      comparator_slice #(.CHUNK(CHUNK)) u_slice (
         .i_a  (a_x[g*CHUNK +: CHUNK]),
         .i_b  (b_x[g*CHUNK +: CHUNK]),
         .o_eq (eq_d[g]),
         .o_gt (gt_d[g])
      );
   end

`ifdef CMP_FP_MODE_EN
   localparam int EXP_LSB = FP_MAN_W;
   localparam int EXP_MSB = FP_MAN_W + FP_EXP_W - 1;

   logic fp_q, nan_q, zero_q, sa_q, sb_q;
   logic nan_d, zero_d;

   assign nan_d  = (&i_a[EXP_MSB:EXP_LSB] & |i_a[FP_MAN_W-1:0]) |
                   (&i_b[EXP_MSB:EXP_LSB] & |i_b[FP_MAN_W-1:0]);
   assign zero_d = ~|i_a[EXP_MSB:0] & ~|i_b[EXP_MSB:0];

   always_ff @(posedge i_clk) begin
      if (accept) begin
         fp_q   <= (mode_eff == CMP_FP);
         nan_q  <= nan_d;
         zero_q <= zero_d;
         sa_q   <= i_a[WIDTH-1];
         sb_q   <= i_b[WIDTH-1];
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s1_valid_q <= 1'b0;
      end else if (accept) begin
         s1_valid_q <= 1'b1;
      end else if (s1_adv) begin
         s1_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (accept) begin
         eq_q   <= eq_d;
         gt_q   <= gt_d;
         tag1_q <= i_tag;
      end
   end

   always_comb begin
      mag_gt = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!eq_q[i]) mag_gt = gt_q[i];
      end
      mag_eq = &eq_q;

      res_d         = '0;
      res_d.equal   = mag_eq;
      res_d.larger  = ~mag_eq & mag_gt;
      res_d.smaller = ~mag_eq & ~mag_gt;
`ifdef CMP_FP_MODE_EN
      if (fp_q) begin
         if (nan_q) begin
            res_d       = '0;
            res_d.unord = 1'b1;
         end else if (zero_q) begin
            res_d       = '0;
            res_d.equal = 1'b1;
         end else if (sa_q != sb_q) begin
            res_d         = '0;
            res_d.larger  = ~sa_q;
            res_d.smaller = sa_q;
         end else if (sa_q) begin
            res_d.larger  = ~mag_eq & ~mag_gt;
            res_d.smaller = ~mag_eq & mag_gt;
         end
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s2_valid_q <= 1'b0;
         res_q      <= '0;
         tag2_q     <= '0;
      end else if (s2_load) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            res_q  <= res_d;
            tag2_q <= tag1_q;
         end
      end
   end

   assign o_valid   = s2_valid_q;
   assign o_equal   = res_q.equal;
   assign o_larger  = res_q.larger;
   assign o_smaller = res_q.smaller;
   assign o_unord   = res_q.unord;
   assign o_tag     = tag2_q;

endmodule
